// File: rtl/lz4_copy_controller_if.sv
// Token-parser and output-buffer signal bundle for lz4_copy_controller.
// slave = controller view, master = parser/buffer (environment) view.
interface lz4_copy_controller_if #(
    parameter int WORD_SIZE    = 8,
    parameter int ADDRESS_SIZE = 4,
    parameter int LEN_SIZE     = 16
);
    logic                    lit_valid;
    logic [WORD_SIZE-1:0]    lit_data;
    logic                    lit_ready;
    logic                    match_valid;
    logic [ADDRESS_SIZE-1:0] match_offset;
    logic [LEN_SIZE-1:0]     match_length;
    logic                    match_ready;
    logic [ADDRESS_SIZE-1:0] buf_address_r;
    logic [ADDRESS_SIZE-1:0] buf_address_w;
    logic                    buf_write;
    logic [WORD_SIZE-1:0]    buf_data_in;
    logic [WORD_SIZE-1:0]    buf_data_out;

    modport slave (
        input  lit_valid, lit_data, match_valid, match_offset, match_length, buf_data_out,
        output lit_ready, match_ready, buf_address_r, buf_address_w, buf_write, buf_data_in
    );

    modport master (
        output lit_valid, lit_data, match_valid, match_offset, match_length, buf_data_out,
        input  lit_ready, match_ready, buf_address_r, buf_address_w, buf_write, buf_data_in
    );
endinterface

// File: rtl/lz4_copy_controller.sv
// LZ4 output-buffer sequencer: writes literals, expands matches by read-back/re-write.
// Optional LZ4_OUT_STREAM_EN mirrors every buffer write onto out_valid_o/out_data_o.
module lz4_copy_controller #(
    parameter int WORD_SIZE    = 8,
    parameter int ADDRESS_SIZE = 4,
    parameter int LEN_SIZE     = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    lz4_copy_controller_if.slave    bus_if,
    output logic [ADDRESS_SIZE-1:0] wr_ptr_o,
    output logic                    busy_o,
`ifdef LZ4_OUT_STREAM_EN
    output logic                    out_valid_o,
    output logic [WORD_SIZE-1:0]    out_data_o,
`endif
    output logic                    err_offset_o
);
    typedef enum logic [1:0] {IDLE, COPY_RD, COPY_WR} state_t;

    state_t                  state_q;
    logic [ADDRESS_SIZE-1:0] wr_ptr_q;
    logic [ADDRESS_SIZE-1:0] src_q;
    logic [LEN_SIZE-1:0]     remaining_q;
    logic                    err_offset_q;

    logic [ADDRESS_SIZE-1:0] src_d;
    logic                    idle;

    assign idle  = (state_q == IDLE);
    assign src_d = wr_ptr_q - bus_if.match_offset;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            src_q        <= '0;
            remaining_q  <= '0;
            err_offset_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus_if.lit_valid) begin
                        wr_ptr_q <= wr_ptr_q + ADDRESS_SIZE'(1);
                    end else if (bus_if.match_valid) begin
                        src_q       <= src_d;
                        remaining_q <= bus_if.match_length;
                        if (bus_if.match_offset == '0)
                            err_offset_q <= 1'b1;
                        // zero-length or zero-offset commands are consumed with no writes
                        if (bus_if.match_offset != '0 && bus_if.match_length != '0)
                            state_q <= COPY_RD;
                    end
                end
                COPY_RD: state_q <= COPY_WR;
                COPY_WR: begin
                    wr_ptr_q    <= wr_ptr_q + ADDRESS_SIZE'(1);
                    src_q       <= src_q + ADDRESS_SIZE'(1);
                    remaining_q <= remaining_q - LEN_SIZE'(1);
                    state_q     <= (remaining_q > LEN_SIZE'(1)) ? COPY_RD : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write data comes straight from the registered RAM output of the preceding COPY_RD.
    always_comb begin
        bus_if.lit_ready   = 1'b0;
        bus_if.match_ready = 1'b0;
        bus_if.buf_write   = 1'b0;
        bus_if.buf_data_in = bus_if.buf_data_out;
        if (idle)
            bus_if.buf_data_in = bus_if.lit_data;
        if (!reset_i) begin
            bus_if.lit_ready   = idle;
            bus_if.match_ready = idle && !bus_if.lit_valid;
            bus_if.buf_write   = (idle && bus_if.lit_valid) || (state_q == COPY_WR);
        end
    end

    assign bus_if.buf_address_r = src_q;
    assign bus_if.buf_address_w = wr_ptr_q;
    assign wr_ptr_o             = wr_ptr_q;
    assign busy_o               = !idle;
    assign err_offset_o         = err_offset_q;

`ifdef LZ4_OUT_STREAM_EN
    assign out_valid_o = bus_if.buf_write;
    assign out_data_o  = bus_if.buf_data_in;
`endif
endmodule
